dac_readback_rx: RTL and testbench
==================================

// Module: dac_readback_rx
// PURPOSE
//  Serial readback receiver for the four HV DAC lanes. Deserialises 16-bit frames returned on
//  dac_dout while the shared chip-select is low, decodes the address/data fields, and stores
//  the 10-bit codes into a 320-bit readback image.
//  Sits beside the DAC write controller in the FECFM HV path, so firmware can confirm the
//  programmed HV settings.
// PARAMETERS
//  NLANE      4   DAC lanes (serial data lines)
//  NCH        8   channels per DAC (addresses ADDR_BASE..ADDR_BASE+NCH-1)
//  DW         10  code width per channel
//  FRAME_BITS 16  bits per frame, MSB first
//  ADDR_BASE  2   address field value of channel 0
// PORTS
//  clkin         in   1            DAC serial clock; all logic on rising edge
//  reset         in   1            asynchronous, active-high
//  dac_cs        in   NLANE        frame strobe, low = shifting; only dac_cs[0] is used (all bits identical)
//  dac_dout      in   NLANE        serial readback data, lane i on bit i
//  hv_reg_din    in   NLANE*NCH*DW expected codes; index lane*NCH+ch, 10 bits each
//  rb_clear      in   1            sync pulse: clears rb_captured, rb_mismatch, rb_all_done
//  rb_data       out  NLANE*NCH*DW readback image, same packing as hv_reg_din
//  rb_word_valid out  1            1-cycle pulse: a valid in-range frame was stored
//  rb_last_addr  out  4            address field of the last decoded frame
//  rb_captured   out  NLANE*NCH    per-channel "written since clear" flags
//  rb_all_done   out  1            high while all rb_captured bits are 1
//  rb_mismatch   out  NLANE*NCH    per-channel readback != expected (see CONFIGURATION)
//  rb_err_short  out  1            1-cycle pulse: frame ended with fewer than FRAME_BITS bits
//  rb_err_long   out  1            1-cycle pulse: frame exceeded FRAME_BITS bits
// BEHAVIOUR
//  - Reset: all outputs 0, rb_data 0, FSM in IDLE, bit counter 0, shift registers 0.
//  - FSM states: IDLE, SHIFT, DECODE.
//    IDLE: dac_cs[0]==0 at a rising edge -> SHIFT. That edge samples bit 15 of every lane; bitcnt=1.
//    SHIFT, cs low: shift {sr,dac_dout[i]} and bitcnt++ while bitcnt<FRAME_BITS.
//      At bitcnt==FRAME_BITS, further low cycles do not shift; set a long flag.
//    SHIFT, cs high: ->DECODE if bitcnt==FRAME_BITS; otherwise pulse rb_err_short and ->IDLE, frame dropped.
//    DECODE (1 cycle): per lane addr=sr[15:12], code=sr[11:2], sr[1:0] ignored.
//      rb_last_addr=lane-0 addr. Pulse rb_err_long if the long flag is set (the frame is still decoded).
//      If ADDR_BASE<=addr<ADDR_BASE+NCH, for each lane with ch=addr-ADDR_BASE:
//      rb_data slot lane*NCH+ch <= code, rb_captured bit set, rb_word_valid pulses.
//      Out-of-range addr (e.g. 0x0 preamble 16'h00FF): no store, no pulse, no error. ->IDLE,
//      or ->SHIFT directly if cs is already low again (back-to-back frames lose no bit).
//  - Latency: stored data is visible 1 cycle after the cs rising edge, i.e. on the DECODE edge.
//  - rb_clear: takes priority over a simultaneous DECODE set of the flags; rb_data is not cleared.
//  - rb_all_done is registered; it rises the cycle after the last rb_captured bit sets.
//  - Reset mid-frame: the partial frame is discarded, no error pulse.
// CONFIGURATION
//  RB_COMPARE_EN defined: in DECODE, rb_mismatch[k] <= (code != hv_reg_din slot k) for each stored slot k.
//    The flag is sticky until rb_clear.
//  RB_COMPARE_EN undefined: rb_mismatch tied to 0; no comparator logic; hv_reg_din unused.
// TESTING
//  1 Reset held, toggle dac_dout -> all outputs 0; release, cs high -> FSM stays IDLE, no pulses.
//  2 Frame 16'h2_3FC on lane0 (addr 2, code 10'h0FF), 16'h2004 on lane1 -> rb_data[9:0]=0x0FF,
//    rb_data[89:80]=0x001, rb_captured bits 0 and 8 set, one rb_word_valid pulse.
//  3 Full 9-frame sequence (preamble 16'h00FF, then addr 2..9 per lane) -> preamble ignored,
//    rb_all_done=1 after the last frame, rb_data equals the driven codes.
//  4 cs low for 10 clocks -> rb_err_short pulse, rb_data unchanged; cs low for 20 clocks ->
//    rb_err_long pulse, first 16 bits decoded.
//  5 RB_COMPARE_EN: expected slot 3=10'h155, readback 10'h154 -> rb_mismatch[3]=1, others 0;
//    rb_clear -> 0. Without the macro -> rb_mismatch stays 0.
//  6 Assert reset at bit 8 of a frame -> outputs cleared, no pulse; next full frame decodes correctly.

Source files
------------

// File: rtl/dac_readback_rx_if.sv
// Serial readback bus from the HV DAC lanes: shared frame strobe plus one data line per lane.
interface dac_readback_rx_if #(
  parameter int NLANE = 4
);
  logic [NLANE-1:0] dac_cs;
  logic [NLANE-1:0] dac_dout;

  modport master (output dac_cs, output dac_dout);
  modport slave  (input  dac_cs, input  dac_dout);
endinterface

// File: rtl/dac_readback_rx.sv
// Readback receiver for the HV DAC lanes: deserialises 16-bit frames and builds the code image.
// Optional comparator against the programmed codes is enabled by defining RB_COMPARE_EN.
module dac_readback_rx #(
  parameter int NLANE      = 4,
  parameter int NCH        = 8,
  parameter int DW         = 10,
  parameter int FRAME_BITS = 16,
  parameter int ADDR_BASE  = 2
) (
  input  logic                    clkin,
  input  logic                    reset,
  dac_readback_rx_if.slave        dac,
  input  logic [NLANE*NCH*DW-1:0] hv_reg_din,
  input  logic                    rb_clear,
  output logic [NLANE*NCH*DW-1:0] rb_data,
  output logic                    rb_word_valid,
  output logic [3:0]              rb_last_addr,
  output logic [NLANE*NCH-1:0]    rb_captured,
  output logic                    rb_all_done,
  output logic [NLANE*NCH-1:0]    rb_mismatch,
  output logic                    rb_err_short,
  output logic                    rb_err_long
);

  localparam int              CW        = $clog2(FRAME_BITS + 1);
  localparam int              SW        = $clog2(NLANE * NCH);
  localparam logic [CW-1:0]   BITS_FULL = CW'(FRAME_BITS);
  localparam logic [3:0]      ADDR_LO   = 4'(ADDR_BASE);
  localparam logic [3:0]      ADDR_HI   = 4'(ADDR_BASE + NCH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t                             state, state_nxt;
  logic   [NLANE-1:0][FRAME_BITS-1:0] sr;
  logic   [CW-1:0]                    bitcnt;
  logic                               long_flag;
  logic                               cs;

  logic frame_start, shift_en, set_long, short_err, decode_en;

  logic [3:0]    lane_addr [NLANE];
  logic [DW-1:0] lane_code [NLANE];
  logic [SW-1:0] lane_slot [NLANE];
  logic [NLANE-1:0] lane_hit;

  // All lanes share one strobe; only bit 0 is looked at.
  assign cs = dac.dac_cs[0];
  logic unused_cs;
  assign unused_cs = ^dac.dac_cs[NLANE-1:1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    set_long    = 1'b0;
    short_err   = 1'b0;
    decode_en   = 1'b0;
    unique case (state)
      IDLE: if (!cs) begin
        state_nxt   = SHIFT;
        frame_start = 1'b1;
      end
      SHIFT: begin
        if (!cs) begin
          if (bitcnt < BITS_FULL) shift_en = 1'b1;
          else                    set_long = 1'b1;
        end else if (bitcnt == BITS_FULL) begin
          state_nxt = DECODE;
        end else begin
          short_err = 1'b1;
          state_nxt = IDLE;
        end
      end
      DECODE: begin
        decode_en = 1'b1;
        // Strobe already low again: this edge carries the next frame's first bit.
        if (!cs) begin
          state_nxt   = SHIFT;
          frame_start = 1'b1;
        end else begin
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      bitcnt    <= '0;
      long_flag <= 1'b0;
    end else begin
      if (frame_start) begin
        for (int l = 0; l < NLANE; l++) sr[l] <= {sr[l][FRAME_BITS-2:0], dac.dac_dout[l]};
        bitcnt    <= CW'(1);
        long_flag <= 1'b0;
      end else if (shift_en) begin
        for (int l = 0; l < NLANE; l++) sr[l] <= {sr[l][FRAME_BITS-2:0], dac.dac_dout[l]};
        bitcnt <= bitcnt + CW'(1);
      end
      if (set_long) long_flag <= 1'b1;
    end
  end

  // Frame layout per lane: addr[15:12], code[11:2], two don't-care bits.
  always_comb begin
    for (int l = 0; l < NLANE; l++) begin
      lane_addr[l] = sr[l][FRAME_BITS-1 -: 4];
      lane_code[l] = sr[l][FRAME_BITS-5 -: DW];
      lane_hit[l]  = (lane_addr[l] >= ADDR_LO) && (lane_addr[l] <= ADDR_HI);
      lane_slot[l] = SW'(l * NCH) + SW'(lane_addr[l] - ADDR_LO);
    end
  end

  // NOTE: rb_data is a register image rather than a RAM, so it takes the asynchronous reset too.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      rb_data       <= '0;
      rb_word_valid <= 1'b0;
      rb_last_addr  <= '0;
      rb_captured   <= '0;
      rb_all_done   <= 1'b0;
      rb_err_short  <= 1'b0;
      rb_err_long   <= 1'b0;
    end else begin
      rb_word_valid <= decode_en && (|lane_hit);
      rb_err_short  <= short_err;
      rb_err_long   <= decode_en && long_flag;
      rb_all_done   <= &rb_captured;
      if (decode_en) begin
        rb_last_addr <= lane_addr[0];
        for (int l = 0; l < NLANE; l++) begin
          if (lane_hit[l]) begin
            rb_data[lane_slot[l]*DW +: DW] <= lane_code[l];
            rb_captured[lane_slot[l]]      <= 1'b1;
          end
        end
      end
      // Clear wins over a coincident decode; the image itself is kept.
      if (rb_clear) begin
        rb_captured <= '0;
        rb_all_done <= 1'b0;
      end
    end
  end

`ifdef RB_COMPARE_EN
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      rb_mismatch <= '0;
    end else if (rb_clear) begin
      rb_mismatch <= '0;
    end else if (decode_en) begin
      for (int l = 0; l < NLANE; l++) begin
        if (lane_hit[l] && (lane_code[l] != hv_reg_din[lane_slot[l]*DW +: DW]))
          rb_mismatch[lane_slot[l]] <= 1'b1;
      end
    end
  end
`else
  assign rb_mismatch = '0;
  logic unused_hv;
  assign unused_hv = ^hv_reg_din;
`endif

endmodule

// File: tb/tb_dac_readback_rx.sv
// Randomised bench for dac_readback_rx against a frame-level reference model.
module tb_dac_readback_rx;
  localparam int NLANE = 4;
  localparam int NCH   = 8;
  localparam int DW    = 10;
  localparam int NSLOT = NLANE * NCH;
  localparam int IW    = NSLOT * DW;

  logic              clkin = 1'b0;
  logic              reset;
  logic [IW-1:0]     hv_reg_din;
  logic              rb_clear;
  logic [IW-1:0]     rb_data;
  logic              rb_word_valid;
  logic [3:0]        rb_last_addr;
  logic [NSLOT-1:0]  rb_captured;
  logic              rb_all_done;
  logic [NSLOT-1:0]  rb_mismatch;
  logic              rb_err_short;
  logic              rb_err_long;

  dac_readback_rx_if #(.NLANE(NLANE)) bus ();

  dac_readback_rx dut (
    .clkin        (clkin),
    .reset        (reset),
    .dac          (bus),
    .hv_reg_din   (hv_reg_din),
    .rb_clear     (rb_clear),
    .rb_data      (rb_data),
    .rb_word_valid(rb_word_valid),
    .rb_last_addr (rb_last_addr),
    .rb_captured  (rb_captured),
    .rb_all_done  (rb_all_done),
    .rb_mismatch  (rb_mismatch),
    .rb_err_short (rb_err_short),
    .rb_err_long  (rb_err_long)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one entry per channel slot plus expected pulse totals.
  int   exp_code [NSLOT];
  bit   exp_cap  [NSLOT];
  bit   exp_mis  [NSLOT];
  int   exp_last;
  int   exp_valid, exp_short, exp_long;
  int   cnt_valid, cnt_short, cnt_long;

  always @(negedge clkin) begin
    if (rb_word_valid) cnt_valid++;
    if (rb_err_short)  cnt_short++;
    if (rb_err_long)   cnt_long++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NSLOT; k++) begin
      exp_code[k] = 0;
      exp_cap[k]  = 0;
      exp_mis[k]  = 0;
    end
    exp_last = 0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NSLOT; k++) begin
      exp_cap[k] = 0;
      exp_mis[k] = 0;
    end
  endtask

  // A frame of nbits strobe-low clocks, decoded as the spec describes.
  task automatic model_frame(input logic [NLANE-1:0][15:0] w, input int nbits);
    bit any;
    int addr, code, k;
    if (nbits < 16) begin
      exp_short++;
      return;
    end
    if (nbits > 16) exp_long++;
    any = 0;
    for (int l = 0; l < NLANE; l++) begin
      addr = int'(w[l][15:12]);
      code = int'(w[l][11:2]);
      if (addr >= 2 && addr < 2 + NCH) begin
        k = l * NCH + addr - 2;
        exp_code[k] = code;
        exp_cap[k]  = 1;
`ifdef RB_COMPARE_EN
        if (code != int'(hv_reg_din[k*DW +: DW])) exp_mis[k] = 1;
`endif
        any = 1;
      end
    end
    if (any) exp_valid++;
    exp_last = int'(w[0][15:12]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic send_frame(input logic [NLANE-1:0][15:0] w, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      @(negedge clkin);
      bus.dac_cs = '0;
      for (int l = 0; l < NLANE; l++)
        bus.dac_dout[l] = (b < 16) ? w[l][15-b] : 1'($urandom);
    end
    @(negedge clkin);
    bus.dac_cs   = '1;
    bus.dac_dout = 4'($urandom);
    model_frame(w, nbits);
  endtask

  task automatic pulse_clear();
    @(negedge clkin);
    rb_clear = 1'b1;
    @(negedge clkin);
    rb_clear = 1'b0;
    model_clear();
  endtask

  task automatic check_all(input string tag);
    logic [IW-1:0]    d;
    logic [NSLOT-1:0] c, m;
    bit               all;
    all = 1;
    for (int k = 0; k < NSLOT; k++) begin
      d[k*DW +: DW] = DW'(exp_code[k]);
      c[k] = exp_cap[k];
      m[k] = exp_mis[k];
      all  = all & exp_cap[k];
    end
    check({tag, "_data"},     rb_data, d);
    check({tag, "_captured"}, IW'(rb_captured), IW'(c));
    check({tag, "_mismatch"}, IW'(rb_mismatch), IW'(m));
    check({tag, "_all_done"}, IW'(rb_all_done), IW'(all));
    check({tag, "_last_addr"}, IW'(rb_last_addr), IW'(exp_last));
    check({tag, "_n_valid"},  IW'(cnt_valid), IW'(exp_valid));
    check({tag, "_n_short"},  IW'(cnt_short), IW'(exp_short));
    check({tag, "_n_long"},   IW'(cnt_long),  IW'(exp_long));
  endtask

  function automatic logic [15:0] mk_word(input int addr, input int code);
    return {4'(addr), 10'(code), 2'($urandom)};
  endfunction

  initial begin
    logic [NLANE-1:0][15:0] w;
    int                     nb, gap;

    reset        = 1'b1;
    rb_clear     = 1'b0;
    bus.dac_cs   = '1;
    bus.dac_dout = '0;
    for (int k = 0; k < NSLOT; k++) hv_reg_din[k*DW +: DW] = DW'($urandom);
    exp_valid = 0; exp_short = 0; exp_long = 0;
    model_reset();

    // 1: reset held with the data lines toggling, then idle with strobe high.
    for (int i = 0; i < 6; i++) begin
      @(negedge clkin);
      bus.dac_dout = 4'($urandom);
    end
    check("rst_data",  rb_data, '0);
    check("rst_flags", IW'({rb_word_valid, rb_all_done, rb_err_short, rb_err_long, rb_last_addr}), '0);
    check("rst_cap_mis", IW'({rb_captured, rb_mismatch}), '0);
    @(negedge clkin);
    reset = 1'b0;
    idle(5);
    check_all("idle");

    // 2: single frame on lanes 0/1, with the one-cycle decode latency checked.
    w[0] = 16'h23FC; w[1] = 16'h2004; w[2] = 16'h0000; w[3] = 16'h0000;
    send_frame(w, 16);
    @(negedge clkin);
    check("lat_valid_early", IW'(rb_word_valid), '0);
    check("lat_cap_early",   IW'(rb_captured), '0);
    @(negedge clkin);
    check("lat_valid", IW'(rb_word_valid), IW'(1));
    check("lane0_code", IW'(rb_data[9:0]), IW'(10'h0FF));
    check("lane1_code", IW'(rb_data[89:80]), IW'(10'h001));
    check("cap_0_8", IW'(rb_captured), IW'(32'h0000_0101));
    idle(2);
    check_all("single");

    // 3: preamble then a full sweep of addresses, frames back to back.
    pulse_clear();
    idle(2);
    check_all("cleared");
    w = '{default: 16'h00FF};
    send_frame(w, 16);
    for (int a = 2; a < 2 + NCH; a++) begin
      for (int l = 0; l < NLANE; l++) w[l] = mk_word(a, int'($urandom_range(0, 1023)));
      send_frame(w, 16);
    end
    idle(3);
    check("sweep_all_done", IW'(rb_all_done), IW'(1));
    check_all("sweep");

    // 4: short and long frames.
    for (int l = 0; l < NLANE; l++) w[l] = mk_word(3 + l, int'($urandom_range(0, 1023)));
    send_frame(w, 10);
    idle(3);
    check_all("short");
    send_frame(w, 20);
    idle(3);
    check_all("long");

    // 5: comparator on slot 3 (lane 0, address 5).
    pulse_clear();
    hv_reg_din[3*DW +: DW] = 10'h155;
    w[0] = {4'h5, 10'h154, 2'b00}; w[1] = 16'h0; w[2] = 16'h0; w[3] = 16'h0;
    send_frame(w, 16);
    idle(3);
`ifdef RB_COMPARE_EN
    check("mis_slot3", IW'(rb_mismatch), IW'(32'h0000_0008));
`else
    check("mis_off", IW'(rb_mismatch), '0);
`endif
    check_all("compare");
    pulse_clear();
    idle(1);
    check("mis_cleared", IW'(rb_mismatch), '0);

    // 6: reset at bit 8 of a frame, then a clean frame.
    for (int b = 0; b < 8; b++) begin
      @(negedge clkin);
      bus.dac_cs   = '0;
      bus.dac_dout = 4'($urandom);
    end
    @(negedge clkin);
    reset      = 1'b1;
    bus.dac_cs = '1;
    model_reset();
    idle(2);
    check("midrst_data", rb_data, '0);
    check("midrst_flags", IW'({rb_captured, rb_word_valid, rb_err_short, rb_err_long, rb_all_done}), '0);
    reset = 1'b0;
    for (int l = 0; l < NLANE; l++) w[l] = mk_word(2 + 2 * l, int'($urandom_range(0, 1023)));
    send_frame(w, 16);
    idle(3);
    check_all("post_rst");

    // Random traffic: mixed addresses, lengths and gaps, with occasional clears.
    for (int it = 0; it < 80; it++) begin
      for (int l = 0; l < NLANE; l++) w[l] = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       nb = int'($urandom_range(1, 15));
        1:       nb = int'($urandom_range(17, 24));
        default: nb = 16;
      endcase
      send_frame(w, nb);
      gap = int'($urandom_range(0, 2));
      idle(gap);
      if (it % 10 == 9) begin
        idle(3);
        check_all("rand");
        if ($urandom_range(0, 1) == 1) pulse_clear();
      end
    end
    idle(3);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
